uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sampler.sv | 37 +++
 rtl/uart_rx_core.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver FSM state encoding and parity-mode constants
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchronizer and 2-of-3 mid-bit majority voter
module uart_rx_sampler #(
  parameter int OVS = 16,
  parameter int CW  = 4
) (
  input  logic          clkfa,
  input  logic          reset,
  input  logic          rx_i,
  input  logic [CW-1:0] cnt_i,
  output logic          rx_s_o,
  output logic          maj_o
);

  localparam logic [CW-1:0] S0_AT = CW'(OVS/2 - 1);
  localparam logic [CW-1:0] S1_AT = CW'(OVS/2);

  logic [1:0] sync_q;
  logic       s0_q;
  logic       s1_q;

  // The third vote is the live synchronized line at cnt = OVS/2+1.
  always_ff @(posedge clkfa or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      if (cnt_i == S0_AT) s0_q <= sync_q[1];
      if (cnt_i == S1_AT) s1_q <= sync_q[1];
    end
  end

  assign rx_s_o = sync_q[1];
  assign maj_o  = (s0_q & s1_q) | (s0_q & sync_q[1]) | (s1_q & sync_q[1]);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampled UART receiver: frame FSM, holding register, error pulses
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clkfa,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_full,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(OVS);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_DEC   = CW'(OVS/2 + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_IS_ODD = 1'(PARITY == PAR_ODD);

  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 ferr_q;
  logic                 perr_q;

  logic rx_s;
  logic maj;
  logic dec_tick;
  logic last_tick;
  logic par_bad;

  uart_rx_sampler #(
    .OVS (OVS),
    .CW  (CW)
  ) u_sampler (
    .clkfa  (clkfa),
    .reset  (reset),
    .rx_i   (rx),
    .cnt_i  (cnt_q),
    .rx_s_o (rx_s),
    .maj_o  (maj)
  );

  assign dec_tick  = (cnt_q == CNT_DEC);
  assign last_tick = (cnt_q == CNT_LAST);
  // Odd mode wants data^p = 1, even wants 0; flipping by the mode bit gives the mismatch flag.
  assign par_bad   = (^shift_q) ^ maj ^ PAR_IS_ODD;

  always_ff @(posedge clkfa or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      rx_data     <= '0;
      rx_full     <= 1'b0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      if (rx_rd && rx_full) rx_full <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q    <= ST_START;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
          end
        end

        ST_START: begin
          if (dec_tick && maj) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (last_tick) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_DATA: begin
          if (dec_tick) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
          if (last_tick) begin
            cnt_q <= '0;
            if (bit_idx_q == IDX_LAST)
              state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              bit_idx_q <= bit_idx_q + IW'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_PARITY: begin
          if (dec_tick) perr_q <= par_bad;
          if (last_tick) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_STOP: begin
          if (dec_tick && (stop_idx_q == STOP_LAST)) begin
            // Leave mid-bit so a start edge right after the stop bit is not missed.
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            frame_err  <= ferr_q | ~maj;
            parity_err <= perr_q;
            if (!rx_full || rx_rd) begin
              rx_data  <= shift_q;
              rx_valid <= 1'b1;
              rx_full  <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end else begin
            if (dec_tick) ferr_q <= ferr_q | ~maj;
            if (last_tick) begin
              cnt_q      <= '0;
              stop_idx_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed bench: default, even-parity and 7N2/OVS=8 receivers
module tb_uart_rx_core;

  logic clkfa = 1'b0;
  logic reset = 1'b1;
  always #5 clkfa = ~clkfa;

  logic       rx_w  [3];
  logic       rd_w  [3];
  logic       vld_w [3];
  logic       full_w[3];
  logic       ferr_w[3];
  logic       perr_w[3];
  logic       ovr_w [3];
  logic [7:0] data_def;
  logic [7:0] data_par;
  logic [6:0] data_d7;

  uart_rx_core u_def (
    .clkfa(clkfa), .reset(reset), .rx(rx_w[0]), .rx_rd(rd_w[0]),
    .rx_data(data_def), .rx_valid(vld_w[0]), .rx_full(full_w[0]),
    .frame_err(ferr_w[0]), .parity_err(perr_w[0]), .overrun_err(ovr_w[0])
  );

  uart_rx_core #(.PARITY(2)) u_par (
    .clkfa(clkfa), .reset(reset), .rx(rx_w[1]), .rx_rd(rd_w[1]),
    .rx_data(data_par), .rx_valid(vld_w[1]), .rx_full(full_w[1]),
    .frame_err(ferr_w[1]), .parity_err(perr_w[1]), .overrun_err(ovr_w[1])
  );

  uart_rx_core #(.DATA_BITS(7), .OVS(8), .STOP_BITS(2)) u_d7 (
    .clkfa(clkfa), .reset(reset), .rx(rx_w[2]), .rx_rd(rd_w[2]),
    .rx_data(data_d7), .rx_valid(vld_w[2]), .rx_full(full_w[2]),
    .frame_err(ferr_w[2]), .parity_err(perr_w[2]), .overrun_err(ovr_w[2])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid[3] = '{0, 0, 0};
  int n_ferr [3] = '{0, 0, 0};
  int n_perr [3] = '{0, 0, 0};
  int n_ovr  [3] = '{0, 0, 0};
  int n_stray[3] = '{0, 0, 0};

  // Error pulses must coincide with rx_valid or overrun_err; anything else is stray.
  always @(negedge clkfa) begin
    for (int k = 0; k < 3; k++) begin
      if (vld_w[k])  n_valid[k]++;
      if (ferr_w[k]) n_ferr[k]++;
      if (perr_w[k]) n_perr[k]++;
      if (ovr_w[k])  n_ovr[k]++;
      if ((ferr_w[k] || perr_w[k]) && !(vld_w[k] || ovr_w[k])) n_stray[k]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input int ticks);
    rx_w[sel] = v;
    repeat (ticks) @(negedge clkfa);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input int ovs, input bit use_par, input logic par_bit,
                            input int nstop, input logic stop_v);
    drive(sel, 1'b0, ovs);
    for (int i = 0; i < nbits; i++) drive(sel, data[i], ovs);
    if (use_par) drive(sel, par_bit, ovs);
    for (int s = 0; s < nstop; s++) drive(sel, stop_v, ovs);
    drive(sel, 1'b1, 2*ovs);
  endtask

  task automatic read_pulse(input int sel);
    rd_w[sel] = 1'b1;
    @(negedge clkfa);
    rd_w[sel] = 1'b0;
    @(negedge clkfa);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rx_w[k] = 1'b1;
      rd_w[k] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clkfa);
    check("reset_data", {24'd0, data_def}, 32'h0);
    check("reset_full", {31'd0, full_w[0]}, 32'h0);
    check("reset_pulses", {28'd0, vld_w[0], ferr_w[0], perr_w[0], ovr_w[0]}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clkfa);

    send_frame(0, 9'h055, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    check("f55_data", {24'd0, data_def}, 32'h55);
    check("f55_valid_cnt", n_valid[0], 1);
    check("f55_err_cnt", n_ferr[0] + n_perr[0] + n_ovr[0], 0);
    check("f55_full", {31'd0, full_w[0]}, 32'h1);
    read_pulse(0);
    check("rd_clears_full", {31'd0, full_w[0]}, 32'h0);
    read_pulse(0);
    check("rd_empty_ignored", {31'd0, full_w[0]}, 32'h0);

    send_frame(0, 9'h00F, 8, 16, 1'b0, 1'b0, 1, 1'b0);
    check("f0f_ferr_cnt", n_ferr[0], 1);
    check("f0f_data", {24'd0, data_def}, 32'h0F);
    check("f0f_valid_cnt", n_valid[0], 2);
    check("f0f_stray", n_stray[0], 0);
    read_pulse(0);

    drive(0, 1'b0, 3);
    drive(0, 1'b1, 40);
    check("glitch_no_valid", n_valid[0], 2);
    check("glitch_no_err", n_ferr[0] + n_perr[0] + n_ovr[0], 1);
    send_frame(0, 9'h081, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    check("f81_data", {24'd0, data_def}, 32'h81);
    check("f81_valid_cnt", n_valid[0], 3);
    read_pulse(0);

    send_frame(0, 9'h011, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    send_frame(0, 9'h022, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    check("ovr_data_kept", {24'd0, data_def}, 32'h11);
    check("ovr_cnt", n_ovr[0], 1);
    check("ovr_valid_cnt", n_valid[0], 4);
    check("ovr_full", {31'd0, full_w[0]}, 32'h1);
    read_pulse(0);
    send_frame(0, 9'h033, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    check("f33_data", {24'd0, data_def}, 32'h33);
    check("f33_valid_cnt", n_valid[0], 5);

    // 0xA3 has four ones, so even parity wants p=0; p=1 is a mismatch.
    send_frame(1, 9'h0A3, 8, 16, 1'b1, 1'b1, 1, 1'b1);
    check("pa3_data", {24'd0, data_par}, 32'hA3);
    check("pa3_perr_cnt", n_perr[1], 1);
    check("pa3_valid_cnt", n_valid[1], 1);
    check("pa3_stray", n_stray[1], 0);
    read_pulse(1);
    send_frame(1, 9'h03C, 8, 16, 1'b1, 1'b0, 1, 1'b1);
    check("p3c_data", {24'd0, data_par}, 32'h3C);
    check("p3c_perr_cnt", n_perr[1], 1);

    // 0x5A LSB first: 0,1,0,1,1,0,1; abort during the third data bit.
    drive(2, 1'b0, 8);
    drive(2, 1'b0, 8);
    drive(2, 1'b1, 8);
    drive(2, 1'b0, 4);
    reset = 1'b1;
    repeat (3) @(negedge clkfa);
    check("rst_mid_data", {25'd0, data_d7}, 32'h0);
    check("rst_mid_full_def", {31'd0, full_w[0]}, 32'h0);
    check("rst_mid_pulses", {28'd0, vld_w[2], ferr_w[2], perr_w[2], ovr_w[2]}, 32'h0);
    rx_w[2] = 1'b1;
    @(negedge clkfa);
    reset = 1'b0;
    repeat (30) @(negedge clkfa);
    check("abort_no_valid", n_valid[2], 0);
    check("abort_no_err", n_ferr[2] + n_perr[2] + n_ovr[2], 0);
    send_frame(2, 9'h05A, 7, 8, 1'b0, 1'b0, 2, 1'b1);
    check("d7_data", {25'd0, data_d7}, 32'h5A);
    check("d7_valid_cnt", n_valid[2], 1);
    check("d7_ferr_cnt", n_ferr[2], 0);
    check("d7_full", {31'd0, full_w[2]}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
